// File: rtl/reg_wr_sched.sv
// reg_wr_sched: per-bank write scheduler in front of the register banks.
//
// Each bank has a single write port. Two producers compete for it: A (PE-tree
// results) and B (memory loads). For every bank, the block:
//   - allocates the lowest free entry from an occupancy bitmap,
//   - arbitrates A/B with a round-robin pointer, and
//   - drives a registered write (enable, address, data) one cycle after the grant.
// Entries return to the free pool when the controller invalidates them.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   pipe_en       global enable; when low there are no grants and no state change
//   a_valid/a_data/a_ready   producer A handshake per bank
//   b_valid/b_data/b_ready   producer B handshake per bank
//   inv/inv_addr  free entry inv_addr[i] of bank i
//   reg_we/reg_wr_addr/reg_wr_data   registered bank write port
//   grant_addr    entry allocated to this cycle's grant (combinational)
//   full          bank has no free entry
//   free_cnt      number of free entries per bank
//   err_inv       sticky: an invalidate hit an entry that was already free
//
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high. ready is combinational from valid and the current state. A producer
// that sees ready low must hold valid and data, because nothing is buffered
// here. ready never depends on ready itself.

module reg_wr_sched #(
  parameter int N_BANKS    = 8,
  parameter int BANK_DEPTH = 32,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = $clog2(BANK_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pipe_en,
  input  logic [N_BANKS-1:0]          a_valid,
  input  logic [N_BANKS*WORD_W-1:0]   a_data,
  output logic [N_BANKS-1:0]          a_ready,
  input  logic [N_BANKS-1:0]          b_valid,
  input  logic [N_BANKS*WORD_W-1:0]   b_data,
  output logic [N_BANKS-1:0]          b_ready,
  input  logic [N_BANKS-1:0]          inv,
  input  logic [N_BANKS*ADDR_W-1:0]   inv_addr,
  output logic [N_BANKS-1:0]          reg_we,
  output logic [N_BANKS*ADDR_W-1:0]   reg_wr_addr,
  output logic [N_BANKS*WORD_W-1:0]   reg_wr_data,
  output logic [N_BANKS*ADDR_W-1:0]   grant_addr,
  output logic [N_BANKS-1:0]          full,
  output logic [N_BANKS*(ADDR_W+1)-1:0] free_cnt,
  output logic                        err_inv
);

  logic [N_BANKS-1:0] err_hit;

  for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
    logic [BANK_DEPTH-1:0] occ_q;
    logic [BANK_DEPTH-1:0] occ_d;
    logic [BANK_DEPTH-1:0] inv_mask;
    logic [BANK_DEPTH-1:0] alloc_mask;
    logic [ADDR_W-1:0]     alloc_idx;
    logic [ADDR_W-1:0]     inv_idx;
    logic [ADDR_W:0]       free_pop;
    logic                  prio_a_q;   // 1: A wins the next contested cycle
    logic                  is_full;
    logic                  can_grant;
    logic                  a_win;
    logic                  b_win;
    logic                  grant;
    logic                  inv_act;
    logic                  we_q;
    logic [ADDR_W-1:0]     waddr_q;
    logic [WORD_W-1:0]     wdata_q;

    assign inv_idx = inv_addr[g*ADDR_W +: ADDR_W];

    // Lowest-index free entry; scanning downwards leaves the smallest index.
    always_comb begin
      alloc_idx = '0;
      for (int j = BANK_DEPTH - 1; j >= 0; j--) begin
        if (!occ_q[j]) alloc_idx = ADDR_W'(j);
      end
    end

    always_comb begin
      free_pop = '0;
      for (int j = 0; j < BANK_DEPTH; j++) begin
        free_pop = free_pop + {{ADDR_W{1'b0}}, ~occ_q[j]};
      end
    end

    assign is_full   = &occ_q;
    assign can_grant = pipe_en && !is_full;
    assign a_win     = can_grant && a_valid[g] && (!b_valid[g] || prio_a_q);
    assign b_win     = can_grant && b_valid[g] && (!a_valid[g] || !prio_a_q);
    assign grant     = a_win || b_win;
    assign inv_act   = pipe_en && inv[g];

    assign alloc_mask = grant   ? ({{(BANK_DEPTH-1){1'b0}}, 1'b1} << alloc_idx) : '0;
    assign inv_mask   = inv_act ? ({{(BANK_DEPTH-1){1'b0}}, 1'b1} << inv_idx)   : '0;

    // Clear before set. An invalidate that lands on the entry being allocated
    // leaves it occupied, and it is flagged through err_hit because that entry
    // was free before the edge.
    assign occ_d = (occ_q & ~inv_mask) | alloc_mask;

    assign err_hit[g] = inv_act && !occ_q[inv_idx];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        occ_q    <= '0;
        prio_a_q <= 1'b1;
        we_q     <= 1'b0;
        waddr_q  <= '0;
        wdata_q  <= '0;
      end else begin
        occ_q <= occ_d;
        we_q  <= grant;
        // The pointer only moves when both producers asked; the loser goes first next time.
        if (grant && a_valid[g] && b_valid[g]) prio_a_q <= b_win;
        if (grant) begin
          waddr_q <= alloc_idx;
          wdata_q <= a_win ? a_data[g*WORD_W +: WORD_W] : b_data[g*WORD_W +: WORD_W];
        end
      end
    end

    assign a_ready[g]                         = a_win;
    assign b_ready[g]                         = b_win;
    assign full[g]                            = is_full;
    assign grant_addr[g*ADDR_W +: ADDR_W]     = alloc_idx;
    assign free_cnt[g*(ADDR_W+1) +: ADDR_W+1] = free_pop;
    assign reg_we[g]                          = we_q;
    assign reg_wr_addr[g*ADDR_W +: ADDR_W]    = waddr_q;
    assign reg_wr_data[g*WORD_W +: WORD_W]    = wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_inv <= 1'b0;
    else if (|err_hit) err_inv <= 1'b1;
  end

endmodule

// File: tb/tb_reg_wr_sched.sv
module tb_reg_wr_sched;
  localparam int N  = 8;
  localparam int D  = 32;
  localparam int W  = 32;
  localparam int AW = 5;

  logic             clk;
  logic             rst;
  logic             pipe_en;
  logic [N-1:0]     a_valid, b_valid, a_ready, b_ready, inv, reg_we, full;
  logic [N*W-1:0]   a_data, b_data, reg_wr_data;
  logic [N*AW-1:0]  inv_addr, reg_wr_addr, grant_addr;
  logic [N*(AW+1)-1:0] free_cnt;
  logic             err_inv;

  reg_wr_sched #(.N_BANKS(N), .BANK_DEPTH(D), .WORD_W(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pipe_en(pipe_en),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .inv(inv), .inv_addr(inv_addr),
    .reg_we(reg_we), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .grant_addr(grant_addr), .full(full), .free_cnt(free_cnt), .err_inv(err_inv)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [D-1:0]  occ_m [N];
  logic          prio_m [N];
  logic          err_m;
  logic [39:0]   exp_q[$];   // {bank[2:0], addr[4:0], data[31:0]}
  int            n_total;
  int            n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*(AW+1)-1:0] model_free_cnt();
    logic [N*(AW+1)-1:0] v;
    for (int i = 0; i < N; i++) v[i*(AW+1) +: AW+1] = 6'(D - $countones(occ_m[i]));
    return v;
  endfunction

  // Asserts reset asynchronously (away from any clock edge), checks the
  // immediate effect, and releases it at the next falling edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_reg_we", 64'(reg_we), 64'd0);
    check("rst_free_cnt", 64'(free_cnt), 64'({N{6'd32}}));
    check("rst_full", 64'(full), 64'd0);
    check("rst_err_inv", 64'(err_inv), 64'd0);
    for (int i = 0; i < N; i++) begin
      occ_m[i]  = '0;
      prio_m[i] = 1'b1;
    end
    err_m = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_wr_addr", 64'(reg_wr_addr), 64'd0);
    for (int i = 0; i < N; i++) check("rst_wr_data", 64'(reg_wr_data[i*W +: W]), 64'd0);
    rst = 1'b1;
  endtask

  // One clock cycle: inputs are already driven (at the falling edge).
  task automatic step();
    logic [N-1:0]    ea, eb, efull;
    logic [N*AW-1:0] ega;
    logic [D-1:0]    nocc [N];
    logic [AW-1:0]   idx, ia;
    logic            nerr;
    logic [39:0]     ent;
    #1;
    nerr = err_m;
    for (int i = 0; i < N; i++) begin
      idx = '0;
      for (int j = D - 1; j >= 0; j--) if (!occ_m[i][j]) idx = AW'(j);
      ega[i*AW +: AW] = idx;
      efull[i] = &occ_m[i];
      ea[i] = pipe_en && !efull[i] && a_valid[i] && (!b_valid[i] || prio_m[i]);
      eb[i] = pipe_en && !efull[i] && b_valid[i] && (!a_valid[i] || !prio_m[i]);
      nocc[i] = occ_m[i];
      ia = inv_addr[i*AW +: AW];
      if (pipe_en && inv[i]) begin
        if (!occ_m[i][ia]) nerr = 1'b1;
        nocc[i][ia] = 1'b0;
      end
      if (ea[i] || eb[i]) begin
        nocc[i][idx] = 1'b1;
        exp_q.push_back({3'(i), idx, ea[i] ? a_data[i*W +: W] : b_data[i*W +: W]});
        if (a_valid[i] && b_valid[i]) prio_m[i] = eb[i];
      end
    end
    check("a_ready", 64'(a_ready), 64'(ea));
    check("b_ready", 64'(b_ready), 64'(eb));
    check("full", 64'(full), 64'(efull));
    check("grant_addr", 64'(grant_addr), 64'(ega));
    @(posedge clk);
    for (int i = 0; i < N; i++) occ_m[i] = nocc[i];
    err_m = nerr;
    #1;
    check("reg_we", 64'(reg_we), 64'(ea | eb));
    for (int i = 0; i < N; i++) begin
      if (reg_we[i]) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          ent = exp_q.pop_front();
          check("wr_bank_addr_data",
                64'({3'(i), reg_wr_addr[i*AW +: AW], reg_wr_data[i*W +: W]}), 64'(ent));
        end
      end
    end
    check("free_cnt", 64'(free_cnt), 64'(model_free_cnt()));
    check("err_inv", 64'(err_inv), 64'(err_m));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_valid = '0; b_valid = '0; inv = '0;
    a_data = '0; b_data = '0; inv_addr = '0;
  endtask

  // ---------------- stimulus ----------------
  logic [N*(AW+1)-1:0] fc_snap;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    pipe_en = 1'b1;
    idle_inputs();
    #2;
    do_reset();

    // Single producer on bank 0: three consecutive grants to entries 0,1,2.
    a_valid = 8'h01;
    a_data[0 +: W] = 32'h11;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t1_addr", 64'(reg_wr_addr[0 +: AW]), 64'(k));
    end
    check("t1_free_cnt", 64'(free_cnt[0 +: AW+1]), 64'd29);
    idle_inputs();

    // Contested bank 2: grants alternate A,B,A,B.
    a_valid = 8'h04;
    b_valid = 8'h04;
    a_data[2*W +: W] = 32'hA;
    b_data[2*W +: W] = 32'hB;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2_addr", 64'(reg_wr_addr[2*AW +: AW]), 64'(k));
      check("t2_data", 64'(reg_wr_data[2*W +: W]), (k % 2 == 0) ? 64'hA : 64'hB);
    end
    idle_inputs();

    // Fill bank 1, free entry 5 while A is still asking, then refill it.
    a_valid = 8'h02;
    for (int k = 0; k < D; k++) begin
      a_data[W +: W] = $urandom;
      step();
    end
    check("t3_full", 64'(full[1]), 64'd1);
    inv = 8'h02;
    inv_addr[AW +: AW] = 5'd5;
    #1;
    check("t3_no_grant_inv_cycle", 64'(a_ready[1]), 64'd0);
    step();
    inv = '0;
    step();
    check("t3_refill_addr", 64'(reg_wr_addr[AW +: AW]), 64'd5);
    check("t3_full_again", 64'(full[1]), 64'd1);
    idle_inputs();

    // Invalidate of a free entry in empty bank 3 sets the sticky error.
    inv = 8'h08;
    inv_addr[3*AW +: AW] = 5'd7;
    step();
    check("t4_err_set", 64'(err_inv), 64'd1);
    idle_inputs();

    // Random traffic; err_inv must stay set throughout.
    for (int k = 0; k < 60; k++) begin
      pipe_en = ($urandom_range(0, 3) != 0);
      a_valid = N'($urandom);
      b_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        a_data[i*W +: W]    = $urandom;
        b_data[i*W +: W]    = $urandom;
        inv[i]              = ($urandom_range(0, 3) == 0);
        inv_addr[i*AW +: AW] = AW'($urandom_range(0, D - 1));
      end
      step();
    end
    check("t4_err_sticky", 64'(err_inv), 64'd1);
    pipe_en = 1'b1;
    idle_inputs();

    // Reset clears the error; then pipe_en=0 freezes everything.
    #2;
    do_reset();
    check("t5_err_cleared", 64'(err_inv), 64'd0);
    pipe_en = 1'b0;
    a_valid = '1;
    b_valid = '1;
    fc_snap = free_cnt;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) a_data[i*W +: W] = $urandom;
      step();
      check("t5_frozen_free_cnt", 64'(free_cnt), 64'(fc_snap));
    end
    pipe_en = 1'b1;
    b_valid = '0;
    step();
    check("t5_resume_we", 64'(reg_we), 64'hFF);
    check("t5_resume_addr", 64'(reg_wr_addr), 64'd0);
    idle_inputs();

    // Asynchronous reset while a write is being presented.
    a_valid = 8'h01;
    a_data[0 +: W] = 32'h5A5A;
    step();
    check("t6_we_before_rst", 64'(reg_we[0]), 64'd1);
    #2;
    do_reset();
    a_valid = 8'h01;
    a_data[0 +: W] = 32'h77;
    step();
    check("t6_addr_after_rst", 64'(reg_wr_addr[0 +: AW]), 64'd0);
    idle_inputs();
    step();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_wr_sched.md
Name: reg_wr_sched

Overview:
- Per-bank write scheduler in front of the register banks. Each bank has one write port, and two producers compete for it: A (PE-tree results) and B (memory loads).
- The block arbitrates the two producers per bank and allocates a free entry from an occupancy bitmap. It drives the banks' write enable, write address and write data.
- Entries return to the free pool when the controller invalidates them on their last read.

Parameters:
- N_BANKS, 8, number of register banks
- BANK_DEPTH, 32, entries per bank (power of 2, ≥2)
- WORD_W, 32, data word width
- ADDR_W, $clog2(BANK_DEPTH), entry address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- pipe_en  in  1  global pipeline enable; when low, no grants and no state change
- a_valid  in  N_BANKS  requester A has a word for bank i
- a_data  in  N_BANKS*WORD_W  requester A data, bank i at [i*WORD_W +: WORD_W]
- a_ready  out  N_BANKS  requester A granted for bank i this cycle
- b_valid  in  N_BANKS  requester B has a word for bank i
- b_data  in  N_BANKS*WORD_W  requester B data
- b_ready  out  N_BANKS  requester B granted for bank i this cycle
- inv  in  N_BANKS  free entry inv_addr[i] of bank i
- inv_addr  in  N_BANKS*ADDR_W  entry to free
- reg_we  out  N_BANKS  registered bank write enable
- reg_wr_addr  out  N_BANKS*ADDR_W  registered write address
- reg_wr_data  out  N_BANKS*WORD_W  registered write data
- grant_addr  out  N_BANKS*ADDR_W  combinational: entry allocated to this cycle's grant
- full  out  N_BANKS  bank i has no free entry
- free_cnt  out  N_BANKS*(ADDR_W+1)  free entries per bank
- err_inv  out  1  sticky: an invalidate targeted an already-free entry

Behaviour:
- Reset (rst=0, async):
  - occupancy bitmaps cleared, so all entries are free
  - reg_we=0, reg_wr_addr=0, reg_wr_data=0, err_inv=0
  - round-robin pointers select A first
  - free_cnt=BANK_DEPTH, full=0
  - A reset mid-operation drops any in-flight write; no partial state survives.
- Allocation, per bank and combinational from the current bitmap:
  - alloc_idx is the lowest-index free entry.
  - full=1 when all entries are occupied.
  - grant_addr=alloc_idx.
- Arbitration, per bank and independent across banks:
  - A grant is possible only when pipe_en=1 and full=0.
  - Only one valid → that requester is granted.
  - Both valid → round-robin: the requester not granted last time wins. The pointer updates only on a contested grant.
  - Readies are combinational and asserted only for the winner. A valid with ready=0 must be held by the producer; the block does not buffer.
- Write, one cycle latency: on a grant at edge t, the following take effect at t+1 and hold for one cycle:
  - reg_we[i]=1
  - reg_wr_addr[i]=alloc_idx
  - reg_wr_data[i]=winner's data
  - the bitmap bit is set
  - reg_we[i]=0 in any cycle without a grant.
- Invalidate, when pipe_en=1 and inv[i]=1:
  - the bitmap bit inv_addr[i] clears at the next edge
  - if that bit was already 0, err_inv is set and stays set until reset.
- Simultaneous invalidate and grant in the same bank and cycle: allocation uses the pre-edge bitmap, so a slot freed this cycle is reusable only from the next cycle. Both updates apply at the same edge.
- Invalidate hitting the entry being allocated in the same cycle: impossible, because the allocated entry is free and therefore flags err_inv; the bit ends set.
- free_cnt equals the popcount of free bits in the registered bitmap. Width is ADDR_W+1 so that BANK_DEPTH is representable.
- pipe_en=0:
  - readies=0 and reg_we=0 next cycle
  - bitmap, pointers and err_inv are frozen
  - inv is ignored.

Test Plan:
- Reset, then a_valid[0]=1 with data 0x11 for 3 cycles → a_ready[0]=1 each cycle; reg_wr_addr[0]=0,1,2 at t+1..t+3; free_cnt[0]=29.
- a_valid[2]=b_valid[2]=1 held for 4 cycles, data A=0xA, B=0xB → grants alternate A,B,A,B; addresses 0,1,2,3 with data 0xA,0xB,0xA,0xB.
- Fill bank 1 with 32 grants → full[1]=1, a_ready[1]=0. Then inv[1]=1 with inv_addr=5 while a_valid[1]=1 → no grant in the inv cycle. Next cycle: grant, reg_wr_addr[1]=5, full[1] returns to 1.
- inv[3]=1 with inv_addr=7 on an empty bank → err_inv=1 and stays 1 through later traffic until rst=0.
- pipe_en=0 with a_valid=all 1s for 5 cycles → all readies=0, reg_we=0, free_cnt unchanged. Raising pipe_en resumes allocation at addr 0.
- Assert rst asynchronously mid-stream while reg_we[0]=1 → reg_we drops immediately, free_cnt=32 in every bank, the next grant uses addr 0.
